// File: rtl/reservation_station.sv
// Reservation station: buffers dispatched instructions, snoops the result bus for
// missing operands and issues the lowest-index ready entry to its execution unit.
module reservation_station #(
    parameter int RS_ID_WIDTH  = 5,
    parameter int RS_OFFSET    = 1,
    parameter int RS_DEPTH     = 4,
    parameter int OPERANDS     = 2,
    parameter int DECODE_WIDTH = 64
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_flush,
    input  logic                            i_input_valid,
    output logic                            o_input_ready,
    input  logic [DECODE_WIDTH-1:0]         i_input_decode,
    input  logic [OPERANDS*32-1:0]          i_op_value,
    input  logic [OPERANDS-1:0]             i_op_present,
    input  logic [OPERANDS*RS_ID_WIDTH-1:0] i_op_rs_id,
    output logic [RS_ID_WIDTH-1:0]          o_id,
    input  logic                            i_result_valid,
    input  logic [RS_ID_WIDTH-1:0]          i_result_rs_id,
    input  logic [31:0]                     i_result_value,
    output logic                            o_output_valid,
    input  logic                            i_output_ready,
    output logic [DECODE_WIDTH-1:0]         o_output_decode,
    output logic [OPERANDS*32-1:0]          o_output_operands,
    output logic [RS_ID_WIDTH-1:0]          o_output_rs_id
);

    localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

    logic [RS_DEPTH-1:0]     r_busy;
    logic [DECODE_WIDTH-1:0] r_decode  [RS_DEPTH];
    logic [OPERANDS-1:0]     r_present [RS_DEPTH];
    logic [31:0]             r_value   [RS_DEPTH][OPERANDS];
    logic [RS_ID_WIDTH-1:0]  r_tag     [RS_DEPTH][OPERANDS];
    logic                    r_hold_valid;
    logic [IDX_W-1:0]        r_hold_idx;

    logic                    w_free_valid;
    logic [IDX_W-1:0]        w_free_idx;
    logic [RS_DEPTH-1:0]     w_ready_vec;
    logic                    w_scan_valid;
    logic [IDX_W-1:0]        w_scan_idx;
    logic                    w_issue_valid;
    logic [IDX_W-1:0]        w_issue_idx;
    logic                    w_dispatch;
    logic                    w_issue_accept;

    // Descending scan so the lowest-index candidate is the last one written.
    always_comb begin
        w_free_valid = 1'b0;
        w_free_idx   = '0;
        w_scan_valid = 1'b0;
        w_scan_idx   = '0;
        w_ready_vec  = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            w_ready_vec[i] = r_busy[i] && (&r_present[i]);
            if (!r_busy[i]) begin
                w_free_valid = 1'b1;
                w_free_idx   = IDX_W'(i);
            end
            if (w_ready_vec[i]) begin
                w_scan_valid = 1'b1;
                w_scan_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        if (r_hold_valid) begin
            w_issue_valid = w_ready_vec[r_hold_idx];
            w_issue_idx   = r_hold_idx;
        end else begin
            w_issue_valid = w_scan_valid;
            w_issue_idx   = w_scan_idx;
        end
    end

    assign w_dispatch     = i_input_valid && w_free_valid;
    assign w_issue_accept = w_issue_valid && i_output_ready;

    assign o_input_ready  = w_free_valid;
    assign o_id           = w_free_valid ? (RS_ID_WIDTH'(RS_OFFSET) + RS_ID_WIDTH'(w_free_idx)) : '0;
    assign o_output_valid = w_issue_valid;
    assign o_output_rs_id = w_issue_valid ? (RS_ID_WIDTH'(RS_OFFSET) + RS_ID_WIDTH'(w_issue_idx)) : '0;

    always_comb begin
        o_output_decode   = '0;
        o_output_operands = '0;
        if (w_issue_valid) begin
            o_output_decode = r_decode[w_issue_idx];
            for (int k = 0; k < OPERANDS; k++) begin
                o_output_operands[k*32 +: 32] = r_value[w_issue_idx][k];
            end
        end
    end

    // Flush wins over a same-cycle dispatch or issue; the hold keeps a stalled issue pinned.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_busy       <= '0;
            r_hold_valid <= 1'b0;
            r_hold_idx   <= '0;
        end else begin
            if (w_issue_accept) begin
                r_busy[w_issue_idx] <= 1'b0;
            end
            if (w_dispatch) begin
                r_busy[w_free_idx] <= 1'b1;
            end
            r_hold_valid <= w_issue_valid && !i_output_ready;
            r_hold_idx   <= w_issue_idx;
        end
    end

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            for (int k = 0; k < OPERANDS; k++) begin
                if (r_busy[i] && !r_present[i][k] && i_result_valid &&
                    (r_tag[i][k] == i_result_rs_id)) begin
                    r_value[i][k]   <= i_result_value;
                    r_present[i][k] <= 1'b1;
                end
            end
        end
        if (w_dispatch) begin
            r_decode[w_free_idx] <= i_input_decode;
            for (int k = 0; k < OPERANDS; k++) begin
                r_tag[w_free_idx][k] <= i_op_rs_id[k*RS_ID_WIDTH +: RS_ID_WIDTH];
                if (i_op_present[k]) begin
                    r_value[w_free_idx][k]   <= i_op_value[k*32 +: 32];
                    r_present[w_free_idx][k] <= 1'b1;
                end else if (i_result_valid &&
                             (i_op_rs_id[k*RS_ID_WIDTH +: RS_ID_WIDTH] == i_result_rs_id)) begin
                    r_value[w_free_idx][k]   <= i_result_value;
                    r_present[w_free_idx][k] <= 1'b1;
                end else begin
                    r_value[w_free_idx][k]   <= i_op_value[k*32 +: 32];
                    r_present[w_free_idx][k] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench for reservation_station: directed scenarios followed by
// randomized traffic compared against an entry-array reference model.
module tb_reservation_station;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, flush, inValid, inReady;
    logic [63:0] inDecode;
    logic [63:0] opValue;
    logic [1:0]  opPresent;
    logic [9:0]  opRsId;
    logic [4:0]  id;
    logic        resValid;
    logic [4:0]  resId;
    logic [31:0] resValue;
    logic        outValid, outReady;
    logic [63:0] outDecode;
    logic [63:0] outOperands;
    logic [4:0]  outRsId;

    int checks = 0;
    int errors = 0;

    // Reference model: one record per slot, plus the pinned stalled slot.
    bit          mBusy [DEPTH];
    logic [63:0] mDecode [DEPTH];
    bit          mPres [DEPTH][2];
    logic [31:0] mVal [DEPTH][2];
    logic [4:0]  mTag [DEPTH][2];
    bit          mStall;
    int          mStallIdx;

    bit          pReady;
    int          pFree;
    logic [4:0]  pId;
    bit          pValid;
    int          pIdx;

    always #5 clk = ~clk;

    reservation_station dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_flush           (flush),
        .i_input_valid     (inValid),
        .o_input_ready     (inReady),
        .i_input_decode    (inDecode),
        .i_op_value        (opValue),
        .i_op_present      (opPresent),
        .i_op_rs_id        (opRsId),
        .o_id              (id),
        .i_result_valid    (resValid),
        .i_result_rs_id    (resId),
        .i_result_value    (resValue),
        .o_output_valid    (outValid),
        .i_output_ready    (outReady),
        .o_output_decode   (outDecode),
        .o_output_operands (outOperands),
        .o_output_rs_id    (outRsId)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic void predict();
        pFree = -1;
        for (int i = 0; i < DEPTH; i++) if (!mBusy[i] && pFree < 0) pFree = i;
        pReady = (pFree >= 0);
        pId    = pReady ? 5'(1 + pFree) : 5'd0;
        pValid = 1'b0;
        pIdx   = 0;
        if (mStall) begin
            pValid = 1'b1;
            pIdx   = mStallIdx;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!pValid && mBusy[i] && mPres[i][0] && mPres[i][1]) begin
                    pValid = 1'b1;
                    pIdx   = i;
                end
            end
        end
    endfunction

    function automatic void clearModel();
        for (int i = 0; i < DEPTH; i++) mBusy[i] = 1'b0;
        mStall    = 1'b0;
        mStallIdx = 0;
    endfunction

    // Applies one clock edge's worth of behaviour using the predictions made before it.
    function automatic void updateModel();
        if (rst || flush) begin
            clearModel();
            return;
        end
        for (int i = 0; i < DEPTH; i++) begin
            for (int k = 0; k < 2; k++) begin
                if (mBusy[i] && !mPres[i][k] && resValid && mTag[i][k] == resId) begin
                    mPres[i][k] = 1'b1;
                    mVal[i][k]  = resValue;
                end
            end
        end
        if (pValid && outReady) mBusy[pIdx] = 1'b0;
        mStall    = pValid && !outReady;
        mStallIdx = pIdx;
        if (inValid && pReady) begin
            mBusy[pFree]   = 1'b1;
            mDecode[pFree] = inDecode;
            for (int k = 0; k < 2; k++) begin
                mTag[pFree][k] = opRsId[k*5 +: 5];
                if (opPresent[k]) begin
                    mPres[pFree][k] = 1'b1;
                    mVal[pFree][k]  = opValue[k*32 +: 32];
                end else if (resValid && opRsId[k*5 +: 5] == resId) begin
                    mPres[pFree][k] = 1'b1;
                    mVal[pFree][k]  = resValue;
                end else begin
                    mPres[pFree][k] = 1'b0;
                end
            end
        end
    endfunction

    task automatic compareAll();
        predict();
        checkOutput("input_ready", 64'(inReady), 64'(pReady));
        checkOutput("id", 64'(id), 64'(pId));
        checkOutput("output_valid", 64'(outValid), 64'(pValid));
        checkOutput("output_rs_id", 64'(outRsId), pValid ? 64'(pIdx + 1) : 64'd0);
        checkOutput("output_decode", outDecode, pValid ? mDecode[pIdx] : 64'd0);
        checkOutput("output_operands", outOperands, pValid ? {mVal[pIdx][1], mVal[pIdx][0]} : 64'd0);
    endtask

    task automatic runCycle();
        compareAll();
        @(posedge clk);
        updateModel();
        #1;
        inValid  = 1'b0;
        resValid = 1'b0;
        flush    = 1'b0;
        rst      = 1'b0;
    endtask

    task automatic applyStimulus(input logic [63:0] dec, input logic [31:0] v0, input logic [31:0] v1,
                                 input logic [1:0] pres, input logic [4:0] t0, input logic [4:0] t1);
        inValid   = 1'b1;
        inDecode  = dec;
        opValue   = {v1, v0};
        opPresent = pres;
        opRsId    = {t1, t0};
    endtask

    task automatic broadcast(input logic [4:0] tag, input logic [31:0] value);
        resValid = 1'b1;
        resId    = tag;
        resValue = value;
    endtask

    logic [1:0] fillPres [DEPTH];
    logic [4:0] fillTag  [DEPTH];

    initial begin
        rst = 1'b1; flush = 1'b0; inValid = 1'b0; inDecode = '0; opValue = '0;
        opPresent = '0; opRsId = '0; resValid = 1'b0; resId = '0; resValue = '0; outReady = 1'b0;
        repeat (2) @(posedge clk);
        clearModel();
        #1 rst = 1'b0;

        $display("[TB] reset state and first dispatch");
        checkOutput("rst_input_ready", 64'(inReady), 64'd1);
        checkOutput("rst_id", 64'(id), 64'd1);
        checkOutput("rst_output_valid", 64'(outValid), 64'd0);
        outReady = 1'b1;
        applyStimulus(64'hA5, 32'd3, 32'd4, 2'b11, 5'd0, 5'd0);
        runCycle();
        checkOutput("first_valid", 64'(outValid), 64'd1);
        checkOutput("first_rs_id", 64'(outRsId), 64'd1);
        checkOutput("first_operands", outOperands, {32'd4, 32'd3});
        checkOutput("first_decode", outDecode, 64'hA5);
        runCycle();
        checkOutput("freed_id", 64'(id), 64'd1);
        checkOutput("freed_valid", 64'(outValid), 64'd0);

        $display("[TB] snoop");
        outReady = 1'b0;
        applyStimulus(64'h2, 32'h11, 32'h0, 2'b01, 5'd0, 5'd7);
        runCycle();
        checkOutput("wait_valid", 64'(outValid), 64'd0);
        broadcast(5'd8, 32'h99);
        runCycle();
        checkOutput("wrong_tag_valid", 64'(outValid), 64'd0);
        broadcast(5'd7, 32'h55);
        runCycle();
        checkOutput("snoop_valid", 64'(outValid), 64'd1);
        checkOutput("snoop_operands", outOperands, {32'h55, 32'h11});
        outReady = 1'b1;
        runCycle();

        $display("[TB] bypass");
        outReady = 1'b0;
        applyStimulus(64'h3, 32'h0, 32'h22, 2'b10, 5'd9, 5'd0);
        broadcast(5'd9, 32'h1234);
        runCycle();
        checkOutput("bypass_valid", 64'(outValid), 64'd1);
        checkOutput("bypass_op0", 64'(outOperands[31:0]), 64'h1234);
        outReady = 1'b1;
        runCycle();

        $display("[TB] fill");
        outReady = 1'b0;
        fillPres[0] = 2'b10; fillTag[0] = 5'd20;
        fillPres[1] = 2'b10; fillTag[1] = 5'd21;
        fillPres[2] = 2'b11; fillTag[2] = 5'd0;
        fillPres[3] = 2'b10; fillTag[3] = 5'd22;
        for (int i = 0; i < DEPTH; i++) begin
            checkOutput("fill_id", 64'(id), 64'(i + 1));
            applyStimulus(64'h100 + 64'(i), 32'(i + 16), 32'(i + 32), fillPres[i], fillTag[i], 5'd0);
            runCycle();
        end
        checkOutput("full_ready", 64'(inReady), 64'd0);
        checkOutput("full_id", 64'(id), 64'd0);
        checkOutput("full_issue_tag", 64'(outRsId), 64'd3);
        applyStimulus(64'hDEAD, 32'd1, 32'd2, 2'b11, 5'd0, 5'd0);
        runCycle();
        outReady = 1'b1;
        runCycle();
        checkOutput("after_issue_ready", 64'(inReady), 64'd1);
        checkOutput("after_issue_id", 64'(id), 64'd3);

        $display("[TB] stall hold");
        outReady = 1'b0;
        broadcast(5'd22, 32'h3333);
        runCycle();
        checkOutput("hold_first_tag", 64'(outRsId), 64'd4);
        broadcast(5'd20, 32'h2020);
        runCycle();
        checkOutput("hold_keep_tag", 64'(outRsId), 64'd4);
        runCycle();
        checkOutput("hold_keep_tag2", 64'(outRsId), 64'd4);
        outReady = 1'b1;
        runCycle();
        checkOutput("hold_next_tag", 64'(outRsId), 64'd1);
        checkOutput("hold_next_op0", 64'(outOperands[31:0]), 64'h2020);

        $display("[TB] flush");
        outReady = 1'b0;
        applyStimulus(64'h77, 32'd5, 32'd6, 2'b11, 5'd0, 5'd0);
        runCycle();
        flush = 1'b1;
        runCycle();
        checkOutput("flush_ready", 64'(inReady), 64'd1);
        checkOutput("flush_id", 64'(id), 64'd1);
        checkOutput("flush_valid", 64'(outValid), 64'd0);
        applyStimulus(64'h88, 32'd7, 32'd8, 2'b11, 5'd0, 5'd0);
        flush = 1'b1;
        runCycle();
        checkOutput("flush_drop_id", 64'(id), 64'd1);
        runCycle();
        checkOutput("flush_drop_valid", 64'(outValid), 64'd0);

        $display("[TB] random traffic");
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                applyStimulus({$urandom, $urandom}, $urandom, $urandom, 2'($urandom),
                              5'($urandom_range(1, 6)), 5'($urandom_range(1, 6)));
            end
            if ($urandom_range(0, 1) == 1) broadcast(5'($urandom_range(0, 6)), $urandom);
            outReady = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 39) == 0);
            rst      = ($urandom_range(0, 99) == 0);
            runCycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reservation_station.md
# reservation_station

Receiving end of the dispatch handshake. Buffers up to RS_DEPTH decoded instructions for one execution unit (add/sub, mul, div, logical, rotate, compare, system, trap), advertises the tag of its next free entry to the dispatcher, and snoops the result bus for missing source operands. It issues each instruction to its unit once all operands are present.

## Interface
Parameters:
- RS_ID_WIDTH, 5: width of tags on the dispatch and result interfaces.
- RS_OFFSET, 1: tag of entry 0; entry i has tag RS_OFFSET+i. Must be ≥1, since tag 0 means "no producer". RS_OFFSET+RS_DEPTH ≤ 2^RS_ID_WIDTH.
- RS_DEPTH, 4: number of entries, 1..16.
- OPERANDS, 2: source operands per instruction.
- DECODE_WIDTH, 64: width of the opaque unit decode payload.

Ports:
- clk, in, 1: single clock. All state updates on the rising edge.
- rst, in, 1: reset. Synchronous, active-high.
- flush, in, 1: synchronous clear of all entries.
- input_valid, in, 1: dispatcher offers an instruction.
- input_ready, out, 1: at least one free entry.
- input_decode, in, DECODE_WIDTH: decode payload.
- op_value, in, OPERANDS×32: source values.
- op_present, in, OPERANDS: operand value is valid at dispatch.
- op_rs_id, in, OPERANDS×RS_ID_WIDTH: producer tag when op_present=0.
- id, out, RS_ID_WIDTH: tag the next accepted instruction receives.
- result_valid, in, 1: result bus broadcast.
- result_rs_id, in, RS_ID_WIDTH: tag of the producing entry.
- result_value, in, 32: broadcast value.
- output_valid, out, 1: issue request to the execution unit.
- output_ready, in, 1: unit accepts.
- output_decode, out, DECODE_WIDTH: payload of the issuing entry.
- output_operands, out, OPERANDS×32: operand values of the issuing entry.
- output_rs_id, out, RS_ID_WIDTH: tag of the issuing entry; the unit returns it on the result bus.

## Operation
- Per-entry state:
  - busy
  - decode
  - per operand: present bit, 32-bit value, waiting tag.
- Free-entry selection: lowest-index non-busy entry, evaluated on the registered busy vector.
- id: RS_OFFSET+index of the selected free entry. Drives 0 when full.
- input_ready: OR of ~busy.
- Dispatch accept (input_valid & input_ready): the selected entry becomes busy and stores decode. For each operand k:
  - op_present[k]=1: store op_value[k] and mark present.
  - op_present[k]=0, and result_valid with result_rs_id==op_rs_id[k] in the same cycle: capture result_value and mark present (bypass).
  - Otherwise: store op_rs_id[k] and mark not present.
- Snoop: every cycle, each busy entry compares every not-present operand's tag with result_rs_id when result_valid=1. On a match it captures result_value and sets present. One broadcast may satisfy several operands and entries.
- Issue selection: lowest-index busy entry whose operands are all present, evaluated on registered state.
  - output_valid=1 iff such an entry exists.
  - output_* driven combinationally from that entry's registers.
- Issue accept (output_valid & output_ready): the selected entry's busy bit clears at the edge.
- Issue selection does not change while output_valid=1 and output_ready=0. A lower-index entry becoming ready does not preempt a stalled issue. The issue-selection pointer is held in a register while the unit stalls.
- flush or rst: all busy bits clear and the stall-hold register clears. flush has priority over a simultaneous dispatch or issue; that dispatch is dropped and that issue is not counted as accepted.

## Timing
- Reset values:
  - input_ready=1
  - id=RS_OFFSET
  - output_valid=0
  - output_decode, output_operands, output_rs_id = 0
- Dispatch with all operands present at edge N: output_valid=1 in cycle N+1 at the earliest.
- Operand captured from the result bus at edge N: the entry is issuable in cycle N+1.
- Freeing is registered. An entry issued at edge N is reported free, and its tag can appear on id, from cycle N+1. A dispatch and an issue in the same cycle never target the same entry.
- Full: input_ready=0 and id=0. A dispatch with input_valid=1 while full is ignored and the dispatcher holds it.
- Full, with a simultaneous issue accept: input_ready stays 0 in that cycle and becomes 1 in the next.
- A result_rs_id with no matching tag has no effect. A result_valid=0 cycle captures nothing, even if the tag matches.

## Test plan
- After rst: input_ready=1, id=RS_OFFSET(1), output_valid=0. Dispatch decode=0xA5 with ops 3 and 4 both present at edge 1. Required: output_valid=1 in cycle 2 with operands {3,4} and output_rs_id=1. Accept; busy clears and id=1 again in cycle 3.
- Dispatch with op1 waiting on tag 7 while output_ready=0. Required: output_valid stays 0. Broadcast result_rs_id=7, value 0x55 → output_valid=1 in the next cycle with op1=0x55. A broadcast on tag 8 changes nothing.
- Bypass: dispatch with op0 waiting on tag 9 while result_valid=1, tag 9, value 0x1234 in the same cycle. Required: the entry issues one cycle later with op0=0x1234.
- Fill all 4 entries with output_ready=0. Required: id sequence 1,2,3,4, then input_ready=0 and id=0. Issue entry 2 (tag 3) → input_ready=1 and id=3 in the following cycle.
- Stall hold: entry 3 is issuing with output_ready=0; entry 0 becomes ready. Required: output_rs_id stays on entry 3 until accepted, then entry 0 issues.
- Assert flush with 3 busy entries, and separately flush in a cycle with input_valid=1. Required: next cycle input_ready=1, id=1, output_valid=0, and the dispatched instruction is absent.
